// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes and state encoding for the multiply/divide unit
package mips_pkg;
   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;
endpackage

// File: rtl/mips_negate2.sv
// mips_negate2: two's-complement negate when en is high, pass-through otherwise
module mips_negate2 #(
   parameter int WIDTH = 32
) (
   input  logic             en,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y
);
   assign y = en ? -x : x;
endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: radix-2 iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
module mips_muldiv_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   md_state_t          state, state_n;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc, mul_next, div_next, prod_fix;
   logic [WIDTH-1:0]   m, a_abs, b_abs, q_fix, r_fix;
   logic [WIDTH:0]     mul_sum, div_t, div_diff;
   logic               neg_p, neg_r, is_div, sgn, sa, sb, req, mul_op, div_op, last, div_zero;
   assign busy     = state != IDLE;
   assign req      = start && !abort;
   assign mul_op   = op == MD_MULT || op == MD_MULTU;
   assign div_op   = op == MD_DIV || op == MD_DIVU;
   assign sgn      = op == MD_MULT || op == MD_DIV;
   assign sa       = sgn && a[WIDTH-1];
   assign sb       = sgn && b[WIDTH-1];
   assign last     = cnt == CNT_W'(WIDTH - 1);
   assign div_zero = m == '0;
   mips_negate2 #(.WIDTH(WIDTH)) u_abs_a (.en(sa), .x(a), .y(a_abs));
   mips_negate2 #(.WIDTH(WIDTH)) u_abs_b (.en(sb), .x(b), .y(b_abs));
   mips_negate2 #(.WIDTH(2*WIDTH)) u_fix_p (.en(neg_p), .x(acc), .y(prod_fix));
   // a zero divisor leaves the all-ones quotient raw and the remainder as the signed dividend
   mips_negate2 #(.WIDTH(WIDTH)) u_fix_q (.en(neg_p && !div_zero), .x(acc[WIDTH-1:0]), .y(q_fix));
   mips_negate2 #(.WIDTH(WIDTH)) u_fix_r (.en(neg_r), .x(acc[2*WIDTH-1:WIDTH]), .y(r_fix));
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? m : '0};
      mul_next = {mul_sum, acc[WIDTH-1:1]};
      div_t    = acc[2*WIDTH-1:WIDTH-1];
      div_diff = div_t - {1'b0, m};
      div_next = div_diff[WIDTH] ? {div_t[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:     state_n = !req ? IDLE : mul_op ? MUL : div_op ? DIV : IDLE;
         MUL, DIV: state_n = abort ? IDLE : last ? FIX : state;
         FIX:      state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         m      <= '0;
         neg_p  <= 1'b0;
         neg_r  <= 1'b0;
         is_div <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
         dbz    <= 1'b0;
      end else begin
         state <= state_n;
         done  <= 1'b0;
         dbz   <= 1'b0;
         case (state)
            IDLE: if (req) begin
               if (op == MD_MTHI) hi <= a;
               if (op == MD_MTLO) lo <= a;
               if (mul_op || div_op) begin
                  acc    <= {{WIDTH{1'b0}}, a_abs};
                  m      <= b_abs;
                  cnt    <= '0;
                  neg_p  <= sa ^ sb;
                  neg_r  <= sa;
                  is_div <= div_op;
               end
            end
            MUL: begin
               acc <= mul_next;
               cnt <= cnt + CNT_W'(1);
            end
            DIV: begin
               acc <= div_next;
               cnt <= cnt + CNT_W'(1);
            end
            FIX: if (!abort) begin
               hi   <= is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
               lo   <= is_div ? q_fix : prod_fix[WIDTH-1:0];
               done <= 1'b1;
               dbz  <= is_div && div_zero;
            end
         endcase
      end
   end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit owning the MIPS HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU (radix-2, one bit per cycle), plus MTHI and MTLO.
- Sits beside the ALU in the datapath. The controller stalls on busy and reads hi/lo for MFHI/MFLO.
- Parametrised in operand width and generalises the single-cycle ALU to a multi-cycle, handshaked functional unit.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation code (package constants).
- a  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b  input  WIDTH  rt operand: multiplier or divisor.
- abort  input  1  pipeline flush; cancels an in-flight operation.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when hi/lo are updated by MULT/DIV.
- dbz  output  1  divide-by-zero flag; valid only with done.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0, dbz=0, counter=0.
- Reset has priority over every other input, including mid-operation.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1:
  - op=MTHI: hi<=a next edge; no busy, no done.
  - op=MTLO: lo<=a next edge; no busy, no done.
  - op=MULT/MULTU: latch operands (absolute values for signed ops), record the result sign, counter<=0, go to MUL.
  - op=DIV/DIVU: same latching and sign recording, go to DIV.
  - Reserved op: ignored.
- start while busy: ignored; no queuing.
- MUL: shift-add over a 2*WIDTH accumulator, one multiplier bit per edge.
- DIV: restoring division, one quotient bit per edge.
- MUL and DIV each run exactly WIDTH edges, then go to FIX.
- FIX, one edge:
  - Apply sign correction: negate the product if the operand signs differ (signed only).
  - Signed divide: quotient negated if signs differ; remainder takes the dividend's sign.
  - Write {hi,lo} = product, or hi=remainder and lo=quotient.
  - Assert done for one cycle; return to IDLE.
- Latency:
  - busy is high in the cycle after the start edge through the FIX cycle.
  - done is high in the cycle after the FIX edge, i.e. cycle WIDTH+2 after start is sampled, with busy=0 in that cycle.
  - For WIDTH=32, done appears 34 cycles after start.
- Back-to-back: start may be asserted in the done cycle and is accepted.
- Divide by zero (b=0, signed or unsigned): hi=a, lo={WIDTH{1'b1}}, dbz=1 with done; full latency still applies.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0; dbz=0.
- abort while busy: IDLE at the next edge; hi/lo unchanged; no done pulse.
- abort in IDLE has no effect. abort and start in the same IDLE cycle: abort wins, request dropped.
- hi/lo are never partially updated; they change only at the FIX edge, an MTHI/MTLO edge, or reset.
- All arithmetic is modulo 2^WIDTH per half. Counter wrap is impossible (CNT_W covers WIDTH).

Decomposition:
- Shared package mips_pkg:
  - MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5; 6, 7 reserved.
  - State encoding: IDLE, MUL, DIV, FIX.
- One sub-module: mips_negate2 — parametrised combinational two's-complement negate with enable, reused for operand absolute values and FIX correction.
- FSM, counter and accumulators stay in mips_muldiv_unit.

Test Plan:
- MULT a=FFFFFFFF, b=00000002 -> done at cycle 34: hi=FFFFFFFF, lo=FFFFFFFE; busy high cycles 1–33.
- MULTU a=FFFFFFFF, b=00000002 -> hi=00000001, lo=FFFFFFFE; then back-to-back DIV a=FFFFFFF9 (-7), b=00000002 issued in the done cycle -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=00000064, b=0 -> hi=00000064, lo=FFFFFFFF, dbz=1 with done; DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, dbz=0.
- MTHI a=12345678, then MTLO a=9ABCDEF0 -> hi/lo updated next edge, busy/done stay 0; MTHI issued while busy -> hi unchanged.
- DIVU started, abort at cycle 10 -> busy=0 at cycle 11, hi/lo keep prior values, done never pulses; start ignored mid-op.
- reset asserted at cycle 5 of MULT -> next cycle hi=lo=0, busy=done=dbz=0, state IDLE; a new MULT then completes normally.
